// File: rtl/fwd_pkg.sv
// Shared constants for the forwarding/hazard controller: forward-select encoding
// and EX/MEM/WB stage-entry layout.
package fwd_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_SEL_REG = 2'd0;
  localparam fwd_sel_t FWD_SEL_EX  = 2'd1;
  localparam fwd_sel_t FWD_SEL_MEM = 2'd2;
  localparam fwd_sel_t FWD_SEL_WB  = 2'd3;

  // Entry index 0 is the youngest in-flight instruction.
  localparam int unsigned NUM_STAGES = 3;
  localparam int unsigned STAGE_EX   = 0;
  localparam int unsigned STAGE_MEM  = 1;
  localparam int unsigned STAGE_WB   = 2;

  // Per-entry fields: valid, wr_en, is_load flags plus an rd of REG_ADDR_W bits.
  localparam int unsigned STAGE_FLAG_W = 3;

endpackage

// File: rtl/fwd_stage_tracker.sv
// EX/MEM/WB destination-register tracker: a 3-entry shift register that advances
// unless held, inserts an invalid entry on bubble and clears on synchronous reset.
module fwd_stage_tracker
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   hold_i,
  input  logic                                   bubble_i,
  input  logic                                   in_valid_i,
  input  logic                                   in_wr_en_i,
  input  logic [REG_ADDR_W-1:0]                  in_rd_i,
  input  logic                                   in_is_load_i,
  output logic [NUM_STAGES-1:0]                  valid_o,
  output logic [NUM_STAGES-1:0]                  wr_en_o,
  output logic [NUM_STAGES-1:0]                  is_load_o,
  output logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] rd_o
);

  logic [NUM_STAGES-1:0]                  valid_q, valid_d;
  logic [NUM_STAGES-1:0]                  wr_en_q, wr_en_d;
  logic [NUM_STAGES-1:0]                  is_load_q, is_load_d;
  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] rd_q, rd_d;

  always_comb begin
    valid_d   = valid_q;
    wr_en_d   = wr_en_q;
    is_load_d = is_load_q;
    rd_d      = rd_q;
    if (!hold_i) begin
      // A bubble enters EX as a fully cleared entry.
      valid_d   = {valid_q[NUM_STAGES-2:0], in_valid_i & ~bubble_i};
      wr_en_d   = {wr_en_q[NUM_STAGES-2:0], in_wr_en_i & ~bubble_i};
      is_load_d = {is_load_q[NUM_STAGES-2:0], in_is_load_i & ~bubble_i};
      rd_d      = {rd_q[NUM_STAGES-2:0], bubble_i ? '0 : in_rd_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q   <= '0;
      wr_en_q   <= '0;
      is_load_q <= '0;
      rd_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      wr_en_q   <= wr_en_d;
      is_load_q <= is_load_d;
      rd_q      <= rd_d;
    end
  end

  assign valid_o   = valid_q;
  assign wr_en_o   = wr_en_q;
  assign is_load_o = is_load_q;
  assign rd_o      = rd_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding and load-use hazard control beside ID.
// Optional FWD_HAZARD_STATS_EN adds stall_cnt/flush_cnt event counters.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned ZERO_REG_HW = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_is_load,
  input  logic                  ex_flush,
  input  logic                  pipe_hold,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall,
  output logic                  ex_bubble
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  logic [NUM_STAGES-1:0]                  st_valid;
  logic [NUM_STAGES-1:0]                  st_wr_en;
  logic [NUM_STAGES-1:0]                  st_is_load;
  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] st_rd;
  logic [NUM_STAGES-1:0]                  match_a;
  logic [NUM_STAGES-1:0]                  match_b;
  logic                                   load_use;

  fwd_stage_tracker #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_tracker (
    .clk_i       (clk),
    .reset_i     (reset),
    .hold_i      (pipe_hold),
    .bubble_i    (ex_bubble),
    .in_valid_i  (id_valid),
    .in_wr_en_i  (id_wr_en),
    .in_rd_i     (id_rd),
    .in_is_load_i(id_is_load),
    .valid_o     (st_valid),
    .wr_en_o     (st_wr_en),
    .is_load_o   (st_is_load),
    .rd_o        (st_rd)
  );

  function automatic logic [NUM_STAGES-1:0] stage_match(
    input logic [REG_ADDR_W-1:0]                  rs,
    input logic                                   use_rs,
    input logic                                   valid_id,
    input logic [NUM_STAGES-1:0]                  v,
    input logic [NUM_STAGES-1:0]                  w,
    input logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] rds
  );
    logic [NUM_STAGES-1:0] m;
    logic                  gate;
    gate = use_rs & valid_id & ~((ZERO_REG_HW != 0) && (rs == '0));
    for (int s = 0; s < NUM_STAGES; s++) begin
      m[s] = gate & v[s] & w[s] & (rds[s] == rs);
    end
    return m;
  endfunction

  // Youngest producer wins; a load still in EX cannot forward yet.
  function automatic fwd_sel_t prio_sel(input logic [NUM_STAGES-1:0] m, input logic ex_load);
    if (m[STAGE_EX])       return ex_load ? FWD_SEL_REG : FWD_SEL_EX;
    else if (m[STAGE_MEM]) return FWD_SEL_MEM;
    else if (m[STAGE_WB])  return FWD_SEL_WB;
    else                   return FWD_SEL_REG;
  endfunction

  always_comb begin
    match_a   = stage_match(id_rs1, id_use_rs1, id_valid, st_valid, st_wr_en, st_rd);
    match_b   = stage_match(id_rs2, id_use_rs2, id_valid, st_valid, st_wr_en, st_rd);
    fwd_sel_a = prio_sel(match_a, st_is_load[STAGE_EX]);
    fwd_sel_b = prio_sel(match_b, st_is_load[STAGE_EX]);
    load_use  = st_is_load[STAGE_EX] & (match_a[STAGE_EX] | match_b[STAGE_EX]);
    stall     = load_use & ~ex_flush;
    ex_bubble = stall | ex_flush;
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!pipe_hold) begin
      if (stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ex_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
